// File: rtl/bus_distributor.sv
// Round-robin stream demultiplexer onto per-channel output registers,
// with per-channel backpressure, enable mask, frame realignment and word count.
module bus_distributor #(
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH  = 6,
    parameter int PULSE_MODE  = 0,
    parameter int CNT_WIDTH   = 16,
    localparam int IW = $clog2(NUM_OUTPUTS)
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   data_valid_in,
    input  logic [DATA_WIDTH-1:0]                  data_line,
    input  logic                                   frame_start_in,
    output logic                                   data_ready_out,
    input  logic [NUM_OUTPUTS-1:0]                 channel_en_in,
    input  logic [NUM_OUTPUTS-1:0]                 out_ready_in,
    output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] output_array,
    output logic [NUM_OUTPUTS-1:0]                 valid_outputs,
    output logic [IW-1:0]                          ix_out,
    output logic [CNT_WIDTH-1:0]                   word_count_out
);

    logic [IW-1:0]                          cur_q, cur_d;
    logic [NUM_OUTPUTS-1:0]                 valid_q, valid_d;
    logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;

    logic [IW-1:0] tgt;
    logic          any_en;
    logic          slot_free;
    logic          accept;

    // First enabled channel at circular offset skip..skip+N-1 from base.
    function automatic logic [IW-1:0] find_en(
        input logic [IW-1:0]          base,
        input logic [NUM_OUTPUTS-1:0] en,
        input int                     skip
    );
        logic [IW-1:0] r;
        logic          hit;
        int            idx;
        r   = base;
        hit = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            idx = (int'(base) + k + skip) % NUM_OUTPUTS;
            if (!hit && en[idx]) begin
                r   = IW'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign any_en = |channel_en_in;

    always_comb begin
        tgt = cur_q;
        if (any_en) begin
            if (frame_start_in) begin
                tgt = find_en('0, channel_en_in, 0);
            end else begin
                tgt = find_en(cur_q, channel_en_in, 0);
            end
        end
    end

    always_comb begin
        slot_free = 1'b1;
        if (PULSE_MODE == 0) begin
            slot_free = !valid_q[tgt] || out_ready_in[tgt];
        end
    end

    assign data_ready_out = any_en && slot_free;
    assign accept         = data_valid_in && data_ready_out;

    always_comb begin
        cur_d  = cur_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (PULSE_MODE != 0) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i] && !out_ready_in[i];
            end
        end
        // A reload wins over drain so back-to-back words leave no bubble.
        if (accept) begin
            valid_d[tgt] = 1'b1;
            data_d[tgt]  = data_line;
            cur_d        = find_en(tgt, channel_en_in, 1);
            cnt_d        = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cur_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            cur_q   <= cur_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign output_array   = data_q;
    assign valid_outputs  = valid_q;
    assign ix_out         = tgt;
    assign word_count_out = cnt_q;

endmodule
